// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: condition codes, FSM states and branch condition evaluation for pc_sequencer.
package pc_pkg;
  typedef enum logic [2:0] {
    COND_NE  = 3'd0,
    COND_EQ  = 3'd1,
    COND_GT  = 3'd2,
    COND_LT  = 3'd3,
    COND_GE  = 3'd4,
    COND_LE  = 3'd5,
    COND_OV  = 3'd6,
    COND_ALW = 3'd7
  } cond_e;
  typedef enum logic {ST_RUN, ST_HALT} state_e;
  function automatic logic cond_true(cond_e c, logic z, logic n, logic v);
    case (c)
      COND_NE: return !z;
      COND_EQ: return z;
      COND_GT: return !z && !n;
      COND_LT: return n;
      COND_GE: return z || !n;
      COND_LE: return z || n;
      COND_OV: return v;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-stage control inputs and PC outputs of pc_sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9
);
  logic              stall;
  logic              branch;
  logic [2:0]        cond;
  logic              Z;
  logic              N;
  logic              V;
  logic              addr_src;
  logic [IMM_W-1:0]  imm_off;
  logic [ADDR_W-1:0] reg_addr;
  logic              call;
  logic              ret;
  logic              hlt;
  logic              resume;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus;
  logic              taken;
  logic              halted;
  logic              ras_err;
  modport master (
    output stall, branch, cond, Z, N, V, addr_src, imm_off, reg_addr, call, ret, hlt, resume,
    input  pc_out, pc_plus, taken, halted, ras_err
  );
  modport slave (
    input  stall, branch, cond, Z, N, V, addr_src, imm_off, reg_addr, call, ret, hlt, resume,
    output pc_out, pc_plus, taken, halted, ras_err
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top;
  logic [PW:0] cnt_q, cnt_d;
  assign top   = ptr_q - PW'(1);
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[top];
  always_comb begin
    ptr_d = push ? ptr_q + PW'(1) : (pop && !empty) ? top : ptr_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + 1'b1) : (pop && !empty) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with conditional branches, stall, sticky halt and
// an optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                INC       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                IMM_W     = 9,
  parameter int                RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus, off, target, ras_top;
  logic err_q, err_d, taken, run_go, full, empty;
  assign pc_plus = pc_q + ADDR_W'(INC);
  assign off     = ADDR_W'($signed(bus.imm_off));
  assign target  = bus.addr_src ? bus.reg_addr : pc_plus + off * ADDR_W'(INC);
  assign taken   = bus.branch && cond_true(cond_e'(bus.cond), bus.Z, bus.N, bus.V);
  assign run_go  = state_q == ST_RUN && !bus.hlt && !bus.stall;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
  pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (run_go && !bus.ret && taken && bus.call),
    .pop  (run_go && bus.ret),
    .din  (pc_plus),
    .dout (ras_top),
    .full (full),
    .empty(empty)
  );
`else
  localparam bit RAS_ON = 1'b0;
  assign ras_top = '0;
  assign full    = 1'b0;
  assign empty   = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    if (state_q == ST_HALT) begin
      state_d = (bus.resume && !bus.hlt) ? ST_RUN : ST_HALT;
      pc_d    = (bus.resume && !bus.hlt) ? pc_plus : pc_q;
    end else if (bus.hlt) begin
      state_d = ST_HALT;
    end else if (RAS_ON && bus.ret && !bus.stall) begin
      pc_d  = empty ? pc_plus : ras_top;
      err_d = empty || bus.call;
    end else if (!bus.stall) begin
      pc_d  = taken ? target : pc_plus;
      err_d = RAS_ON && taken && bus.call && full;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end
  assign bus.pc_out  = pc_q;
  assign bus.pc_plus = pc_plus;
  assign bus.taken   = taken;
  assign bus.halted  = state_q == ST_HALT;
  assign bus.ras_err = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed stimulus against a queue-based reference model with a scoreboard monitor.
module tb_pc_sequencer;
  localparam int AW = 16, IW = 9, INC = 2, D = 4;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pc_sequencer_if #(.ADDR_W(AW), .IMM_W(IW)) bus ();
  pc_sequencer #(.ADDR_W(AW), .INC(INC), .RESET_PC(16'h0000), .IMM_W(IW), .RAS_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {logic tk; logic [15:0] pc; logic hal; logic err;} exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0;
  logic [15:0] m_pc = 16'h0;
  bit m_hal = 1'b0;
  logic [15:0] m_ras[$];

  function automatic bit m_cond(int c, bit z, bit n, bit v);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: advance one edge from the inputs currently driven, queue the expectation.
  task automatic cycle();
    exp_t e;
    logic [15:0] plus, tgt;
    bit tk;
    plus = 16'(int'(m_pc) + INC);
    tk   = bus.branch && m_cond(int'(bus.cond), bus.Z, bus.N, bus.V);
    tgt  = bus.addr_src ? bus.reg_addr : 16'(int'(m_pc) + INC + int'($signed(bus.imm_off)) * INC);
    e.tk = tk;
    e.err = 1'b0;
    if (rst) begin
      m_pc = 16'h0; m_hal = 1'b0; m_ras.delete();
    end else if (m_hal) begin
      if (bus.resume && !bus.hlt) begin m_hal = 1'b0; m_pc = plus; end
    end else if (bus.hlt) begin
      m_hal = 1'b1;
    end else if (!bus.stall) begin
      if (RAS && bus.ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = plus; e.err = 1'b1; end
        if (bus.call) e.err = 1'b1;
      end else begin
        if (RAS && tk && bus.call) begin
          if (m_ras.size() == D) begin void'(m_ras.pop_front()); e.err = 1'b1; end
          m_ras.push_back(plus);
        end
        m_pc = tk ? tgt : plus;
      end
    end
    e.pc = m_pc;
    e.hal = m_hal;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, st, b, input logic [2:0] c, input logic [2:0] f, input bit as,
                       input logic [8:0] imm, input logic [15:0] ra, input bit ca, re, h, rs);
    rst = r; bus.stall = st; bus.branch = b; bus.cond = c;
    {bus.Z, bus.N, bus.V} = f;
    bus.addr_src = as; bus.imm_off = imm; bus.reg_addr = ra;
    bus.call = ca; bus.ret = re; bus.hlt = h; bus.resume = rs;
    cycle();
  endtask

  task automatic seq(int n = 1);
    repeat (n) drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 0, 0);
  endtask
  task automatic jmp(logic [15:0] a, bit ca = 0);
    drive(0, 0, 1, 3'd7, 3'b000, 1, 9'd0, a, ca, 0, 0, 0);
  endtask
  task automatic ret1();
    drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 1, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (q.size() > 0) chk("taken", {15'd0, bus.taken}, {15'd0, q[0].tk});
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out", bus.pc_out, e.pc);
        chk("pc_plus", bus.pc_plus, 16'(e.pc + INC));
        chk("halted", {15'd0, bus.halted}, {15'd0, e.hal});
        chk("ras_err", {15'd0, bus.ras_err}, {15'd0, e.err});
      end
    end
  end

  logic [2:0] ff_false [7] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b000};
  logic [2:0] ff_true  [7] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b100, 3'b100, 3'b001};

  initial begin
    bit b, c7;
    logic [2:0] c;
    @(negedge clk);
    drive(1, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 0, 0);
    seq(3);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 3'(i), ff_false[i], 1, 9'd0, 16'h0040, 0, 0, 0, 0);
      drive(0, 0, 1, 3'(i), ff_true[i], 1, 9'd0, 16'h0040, 0, 0, 0, 0);
    end
    drive(0, 0, 1, 3'd7, 3'bxxx, 1, 9'd0, 16'h0080, 0, 0, 0, 0);
    jmp(16'h0020);
    drive(0, 0, 1, 3'd7, 3'b000, 0, 9'h1FC, 16'h0000, 0, 0, 0, 0);
    jmp(16'hFFFE);
    seq(2);
    jmp(16'h0030);
    drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 1, 0);
    seq(5);
    drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 1, 1);
    drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 0, 1);
    repeat (3) drive(0, 1, 1, 3'd7, 3'b000, 1, 9'd0, 16'h0100, 1, 0, 0, 0);
    seq(1);
    for (int i = 0; i < 5; i++) jmp(16'(16'h0200 + i * 16'h0100), 1);
    repeat (5) ret1();
    jmp(16'h0500, 1);
    drive(0, 0, 1, 3'd7, 3'b000, 1, 9'd0, 16'h0600, 1, 1, 0, 0);
    jmp(16'h0700, 1);
    jmp(16'h0800, 1);
    drive(0, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 1, 0);
    seq(2);
    drive(1, 0, 0, 3'd0, 3'b000, 0, 9'd0, 16'h0, 0, 0, 0, 0);
    ret1();
    seq(1);
    for (int i = 0; i < 2000; i++) begin
      b  = $urandom_range(1) == 1;
      c  = 3'($urandom);
      c7 = b && c == 3'd7;
      drive($urandom_range(63) == 0, $urandom_range(7) == 0, b, c, 3'($urandom), $urandom_range(1) == 1,
            9'($urandom), 16'($urandom), c7 && $urandom_range(2) == 0, $urandom_range(7) == 0,
            $urandom_range(15) == 0, $urandom_range(3) == 0);
    end
    seq(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
